// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and types for the integer register file
// Purpose: default geometry plus the address and data-word types used by the
//          register file, its pending-write counters and their bench.
// Ports:   none (package).
package rf_pkg;

  localparam int XLEN_D = 32;
  localparam int NREG_D = 32;

  typedef logic [4:0]        rf_addr_t;
  typedef logic [XLEN_D-1:0] rf_word_t;

endpackage

// File: rtl/rf_pending_ctr.sv
// rtl/rf_pending_ctr.sv - saturating up/down counter of outstanding writes to one register
// Purpose: counts reservations (inc) against retirements (dec) for a single
//          architectural register; never wraps in either direction.
// Ports:   CLK, RESET (sync, active-high)
//          inc       - reservation accepted this cycle
//          dec       - writeback retired this cycle
//          count     - outstanding writes
//          at_max    - count is all ones; the issuer must stall
//          underflow - retirement seen while nothing was outstanding
module rf_pending_ctr
  import rf_pkg::*;
#(
  parameter int PCW = 2
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           inc,
  input  logic           dec,
  output logic [PCW-1:0] count,
  output logic           at_max,
  output logic           underflow
);

  localparam logic [PCW-1:0] CNT_MAX = '1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (inc && !dec && !at_max) begin
      count <= count + PCW'(1);
    end else if (dec && !inc && (count != '0)) begin
      count <= count - PCW'(1);
    end
  end

  assign at_max    = (count == CNT_MAX);
  assign underflow = dec && (count == '0);

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - parametrised register file with per-register pending-write scoreboard
// Purpose: NREG x XLEN integer register file (x0 hardwired to zero) with NRP
//          combinational read ports and a saturating outstanding-write counter
//          per register so the hazard unit can stall issue.
// Config:  REGFILE_BYPASS_EN - forward the in-flight writeback to matching read
//          ports and drop busy when that writeback retires the last reservation.
// Ports:   CLK, RESET (sync, active-high)
//          WR_EN/WR_ADDR/WR_DATA        - writeback, always accepted
//          ISSUE_EN/ISSUE_ADDR          - destination reservation
//          ISSUE_STALL                  - reservation refused, counter at max
//          RD_ADDR/RD_DATA/RD_BUSY      - packed read ports, port k at slice k
//          WB_ERR                       - sticky: retirement with nothing pending
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int  XLEN = XLEN_D,
  parameter int  NREG = NREG_D,
  parameter int  NRP  = 2,
  parameter int  PCW  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WR_EN,
  input  logic [AW-1:0]     WR_ADDR,
  input  logic [XLEN-1:0]   WR_DATA,
  input  logic              ISSUE_EN,
  input  logic [AW-1:0]     ISSUE_ADDR,
  output logic              ISSUE_STALL,
  input  logic [NRP*AW-1:0] RD_ADDR,
  output logic [NRP*XLEN-1:0] RD_DATA,
  output logic [NRP-1:0]    RD_BUSY,
  output logic              WB_ERR
);

  logic [XLEN-1:0] regs [NREG];
  logic [PCW-1:0]  cnt  [NREG];
  logic [NREG-1:0] at_max;
  logic [NREG-1:0] uf;

  // x0 has no counter: never busy, never stalls, never flags an error.
  assign cnt[0]    = '0;
  assign at_max[0] = 1'b0;
  assign uf[0]     = 1'b0;

  // Stall looks only at the current count, so a same-cycle writeback to the
  // same register cannot release it; keeps the write path off this timing arc.
  assign ISSUE_STALL = ISSUE_EN && (ISSUE_ADDR != '0) && at_max[ISSUE_ADDR];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (WR_EN && (WR_ADDR != '0)) begin
      regs[WR_ADDR] <= WR_DATA;
    end
  end

  for (genvar i = 1; i < NREG; i++) begin : g_ctr
    logic inc;
    logic dec;
    assign inc = ISSUE_EN && !ISSUE_STALL && (ISSUE_ADDR == AW'(i));
    assign dec = WR_EN && (WR_ADDR == AW'(i));

    rf_pending_ctr #(.PCW(PCW)) u_ctr (
      .CLK       (CLK),
      .RESET     (RESET),
      .inc       (inc),
      .dec       (dec),
      .count     (cnt[i]),
      .at_max    (at_max[i]),
      .underflow (uf[i])
    );
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      WB_ERR <= 1'b0;
    end else if (|uf) begin
      WB_ERR <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] stored;
    logic            pending;

    assign addr    = RD_ADDR[k*AW +: AW];
    assign stored  = (addr == '0) ? '0 : regs[addr];
    assign pending = (cnt[addr] != '0);

`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit = WR_EN && (WR_ADDR == addr) && (addr != '0);
    assign RD_DATA[k*XLEN +: XLEN] = hit ? WR_DATA : stored;
    // The forwarded value is final only if this writeback retires the last
    // outstanding reservation.
    assign RD_BUSY[k] = pending && !(hit && (cnt[addr] == PCW'(1)));
`else
    assign RD_DATA[k*XLEN +: XLEN] = stored;
    assign RD_BUSY[k]              = pending;
`endif
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard
// Purpose: drives the register file with four read ports and 2-bit counters
//          through reset, x0, same-cycle read/write, saturation, simultaneous
//          issue/writeback and spurious writeback scenarios.
// Ports:   none (top-level bench).
module tb_regfile_scoreboard;
  import rf_pkg::*;

  localparam int NRP = 4;
  localparam int AW  = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            wr_en = 1'b0;
  rf_addr_t        wr_addr = '0;
  rf_word_t        wr_data = '0;
  logic            issue_en = 1'b0;
  rf_addr_t        issue_addr = '0;
  logic            issue_stall;
  logic [NRP*AW-1:0] rd_addr = '0;
  logic [NRP*32-1:0] rd_data;
  logic [NRP-1:0]  rd_busy;
  logic            wb_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] act;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  regfile_scoreboard #(.XLEN(32), .NREG(32), .NRP(NRP), .PCW(2)) dut (
    .CLK         (clk),
    .RESET       (reset),
    .WR_EN       (wr_en),
    .WR_ADDR     (wr_addr),
    .WR_DATA     (wr_data),
    .ISSUE_EN    (issue_en),
    .ISSUE_ADDR  (issue_addr),
    .ISSUE_STALL (issue_stall),
    .RD_ADDR     (rd_addr),
    .RD_DATA     (rd_data),
    .RD_BUSY     (rd_busy),
    .WB_ERR      (wb_err)
  );

  // kind: 0 data, 1 busy, 2 stall, 3 wb_err
  function automatic logic [31:0] observe(input int kind, input int port);
    case (kind)
      0:       return rd_data[port*32 +: 32];
      1:       return {31'b0, rd_busy[port]};
      2:       return {31'b0, issue_stall};
      default: return {31'b0, wb_err};
    endcase
  endfunction

  // Push the expected value together with the DUT output seen at this moment.
  task automatic note(input string nm, input int kind, input int port, input logic [31:0] exp);
    sb_t e;
    e.name = nm;
    e.exp  = exp;
    e.act  = observe(kind, port);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wr_en    = 1'b0;
    issue_en = 1'b0;
    reset    = 1'b0;
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_rd(input int p, input int a);
    logic [AW-1:0] av;
    av = a[AW-1:0];
    rd_addr[p*AW +: AW] = av;
  endtask

  task automatic do_issue(input int a);
    issue_en   = 1'b1;
    issue_addr = a[4:0];
  endtask

  task automatic do_wr(input int a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a[4:0];
    wr_data = d;
  endtask

  task automatic test_reset();
    sb_t e;
    reset = 1'b1;
    step();
    for (int p = 0; p < NRP; p++) begin
      note("rst_data", 0, p, 32'h0);
      note("rst_busy", 1, p, 32'h0);
    end
    note("rst_stall", 2, 0, 32'h0);
    note("rst_wberr", 3, 0, 32'h0);
    do_issue(5);
    step();
    do_wr(5, 32'hDEADBEEF);
    step();
    set_rd(0, 5);
    settle();
    note("x5_written", 0, 0, 32'hDEADBEEF);
    note("x5_retired_busy", 1, 0, 32'h0);
    reset = 1'b1;
    do_wr(5, 32'h00000001);
    do_issue(5);
    step();
    note("x5_after_rst", 0, 0, 32'h0);
    note("x5_busy_after_rst", 1, 0, 32'h0);
    note("wberr_after_rst", 3, 0, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (e.act !== e.exp) begin
        errors++;
        $display("FAIL %s actual=%h expected=%h", e.name, e.act, e.exp);
      end
    end
  endtask

  task automatic test_zero_reg();
    sb_t e;
    do_wr(0, 32'h12345678);
    step();
    for (int i = 0; i < 4; i++) begin
      do_issue(0);
      settle();
      note("x0_stall", 2, 0, 32'h0);
      step();
    end
    set_rd(1, 0);
    settle();
    note("x0_data", 0, 1, 32'h0);
    note("x0_busy", 1, 1, 32'h0);
    note("x0_wberr", 3, 0, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (e.act !== e.exp) begin
        errors++;
        $display("FAIL %s actual=%h expected=%h", e.name, e.act, e.exp);
      end
    end
  endtask

  task automatic test_same_cycle();
    sb_t e;
    do_issue(7);
    step();
    do_wr(7, 32'h11111111);
    step();
    do_issue(7);
    step();
    set_rd(1, 7);
    settle();
    note("x7_busy_pending", 1, 1, 32'h1);
    note("x7_old", 0, 1, 32'h11111111);
    do_wr(7, 32'hA5A5A5A5);
    settle();
`ifdef REGFILE_BYPASS_EN
    note("x7_same_cycle_data", 0, 1, 32'hA5A5A5A5);
    note("x7_same_cycle_busy", 1, 1, 32'h0);
`else
    note("x7_same_cycle_data", 0, 1, 32'h11111111);
    note("x7_same_cycle_busy", 1, 1, 32'h1);
`endif
    step();
    note("x7_next_data", 0, 1, 32'hA5A5A5A5);
    note("x7_next_busy", 1, 1, 32'h0);
    note("x7_wberr", 3, 0, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (e.act !== e.exp) begin
        errors++;
        $display("FAIL %s actual=%h expected=%h", e.name, e.act, e.exp);
      end
    end
  endtask

  task automatic test_saturation();
    sb_t e;
    set_rd(0, 3);
    for (int i = 0; i < 3; i++) begin
      do_issue(3);
      settle();
      note("x3_no_stall", 2, 0, 32'h0);
      step();
      note("x3_busy_issue", 1, 0, 32'h1);
    end
    do_issue(3);
    settle();
    note("x3_stall_at_max", 2, 0, 32'h1);
    step();
    note("x3_busy_max", 1, 0, 32'h1);
    do_issue(3);
    do_wr(3, 32'h33330001);
    settle();
    note("x3_stall_with_wb", 2, 0, 32'h1);
    step();
    note("x3_busy_wb1", 1, 0, 32'h1);
    do_wr(3, 32'h33330002);
    step();
    note("x3_busy_wb2", 1, 0, 32'h1);
    do_wr(3, 32'h33330003);
    step();
    note("x3_busy_wb3", 1, 0, 32'h0);
    note("x3_data", 0, 0, 32'h33330003);
    note("x3_wberr", 3, 0, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (e.act !== e.exp) begin
        errors++;
        $display("FAIL %s actual=%h expected=%h", e.name, e.act, e.exp);
      end
    end
  endtask

  task automatic test_issue_and_wb();
    sb_t e;
    set_rd(2, 9);
    do_issue(9);
    step();
    note("x9_busy_issue", 1, 2, 32'h1);
    do_issue(9);
    do_wr(9, 32'h99990001);
    settle();
    note("x9_no_stall", 2, 0, 32'h0);
    step();
    note("x9_busy_net0", 1, 2, 32'h1);
    note("x9_data1", 0, 2, 32'h99990001);
    do_wr(9, 32'h99990002);
    step();
    note("x9_busy_final", 1, 2, 32'h0);
    note("x9_data2", 0, 2, 32'h99990002);
    note("x9_wberr", 3, 0, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (e.act !== e.exp) begin
        errors++;
        $display("FAIL %s actual=%h expected=%h", e.name, e.act, e.exp);
      end
    end
  endtask

  task automatic test_spurious_wb();
    sb_t e;
    do_wr(4, 32'hCAFEF00D);
    step();
    set_rd(3, 4);
    settle();
    note("x4_data", 0, 3, 32'hCAFEF00D);
    note("x4_busy", 1, 3, 32'h0);
    note("x4_wberr_set", 3, 0, 32'h1);
    repeat (3) step();
    note("x4_wberr_held", 3, 0, 32'h1);
    set_rd(0, 3);
    set_rd(1, 7);
    set_rd(2, 9);
    set_rd(3, 4);
    settle();
    note("port0_x3", 0, 0, 32'h33330003);
    note("port1_x7", 0, 1, 32'hA5A5A5A5);
    note("port2_x9", 0, 2, 32'h99990002);
    note("port3_x4", 0, 3, 32'hCAFEF00D);
    reset = 1'b1;
    step();
    note("wberr_cleared", 3, 0, 32'h0);
    note("x4_cleared", 0, 3, 32'h0);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (e.act !== e.exp) begin
        errors++;
        $display("FAIL %s actual=%h expected=%h", e.name, e.act, e.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_reg();
    test_same_cycle();
    test_saturation();
    test_issue_and_wb();
    test_spurious_wb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised integer register file with a per-register pending-write scoreboard for the RV32IM pipeline. It replaces the fixed 32x32, two-read-port file in the decode stage. It adds a configurable number of read ports, a hardwired zero register, optional write-to-read bypass, and per-register outstanding-write counters that the hazard unit uses to stall issue. Decode issues destination reservations, writeback retires them, and readers see data and busy status per port.

## Interface
- XLEN, 32: data width in bits.
- NREG, 32: number of registers; power of two, >= 2. AW = $clog2(NREG).
- NRP, 2: number of read ports, 1..4.
- PCW, 2: pending-counter width; max outstanding writes per register = 2^PCW-1.

- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high; sampled on CLK rising edge.
- WR_EN  in  1  writeback strobe.
- WR_ADDR  in  AW  writeback destination.
- WR_DATA  in  XLEN  writeback data.
- ISSUE_EN  in  1  issue strobe: reserves ISSUE_ADDR as pending destination.
- ISSUE_ADDR  in  AW  destination being reserved.
- ISSUE_STALL  out  1  combinational; high when the ISSUE_ADDR counter is at max. Suppresses the reservation.
- RD_ADDR  in  NRP*AW  packed read addresses; port k at bits [k*AW +: AW].
- RD_DATA  out  NRP*XLEN  packed read data; combinational.
- RD_BUSY  out  NRP  per-port busy flag; combinational.
- WB_ERR  out  1  sticky flag: writeback retired a register whose counter was 0.

## Operation
- Storage: NREG x XLEN registers, plus NREG counters of PCW bits each.
- Register 0:
  - Reads 0.
  - Writes are ignored.
  - Counter is never incremented; RD_BUSY for address 0 is always 0.
  - ISSUE_STALL is never asserted for address 0.
- Write: when WR_EN is high and WR_ADDR != 0, REG[WR_ADDR] <= WR_DATA at the edge.
- Counter update for address a, applied per edge:
  - issue only (ISSUE_EN && !ISSUE_STALL && ISSUE_ADDR==a): +1.
  - writeback only (WR_EN && WR_ADDR==a): -1.
  - both on the same a: net 0, count unchanged.
  - both on different addresses: each counter updates independently.
- Writeback with count 0: data is still written, the counter stays 0 (no underflow), and WB_ERR is set.
- ISSUE_STALL = ISSUE_EN && ISSUE_ADDR!=0 && count[ISSUE_ADDR]==max.
  - A writeback to the same address in the same cycle does not clear the stall. This keeps the stall path free of the write path.
- Read port k: RD_DATA = REG[addr_k] (0 for address 0); RD_BUSY = count[addr_k] != 0.
- Reset, at the edge with RESET high:
  - All registers, all counters and WB_ERR go to 0.
  - Overrides any simultaneous WR_EN or ISSUE_EN.
  - A reset mid-operation discards all pending reservations.

## Timing
- Reset values:
  - RD_DATA = 0 on every port.
  - RD_BUSY = 0.
  - WB_ERR = 0.
  - ISSUE_STALL = 0 unless ISSUE_EN is asserted with a nonzero address.
- Write latency:
  - Without bypass, data written at edge n is readable after edge n.
  - A same-cycle read returns the old value.
- Issue-to-busy latency: 1 cycle. The reservation made at edge n shows as RD_BUSY after edge n.
- No handshake back-pressure on writeback; WR_EN is always accepted.
- Read paths are purely combinational from RD_ADDR and state. No internal clocked read.

## Configuration
- REGFILE_BYPASS_EN defined:
  - When WR_EN is high and WR_ADDR == addr_k != 0, RD_DATA for port k = WR_DATA in the same cycle.
  - RD_BUSY for port k = 0 in that cycle if count[addr_k] == 1.
  - A register read in the same cycle as its final writeback is therefore usable without a stall.
- REGFILE_BYPASS_EN undefined:
  - Reads return registered contents only.
  - RD_BUSY ignores the in-flight writeback.
  - The hazard unit must hold the reader one extra cycle.

## Structure
- The shared package rf_pkg holds:
  - Default constants XLEN_D=32, NREG_D=32.
  - A typedef for the register address (logic [4:0]).
  - A typedef for a data word.
- One sub-module, rf_pending_ctr: a single PCW-bit up/down saturating counter.
  - Inputs: inc, dec, reset.
  - Outputs: count, at_max, underflow.
  - Instantiated NREG-1 times in a generate loop; register 0 has no counter.
- Read ports are generated with a for-generate over NRP.

## Test plan
- Reset: write 0xDEADBEEF to x5, then assert RESET for 1 cycle -> read of x5 = 0, RD_BUSY=0, WB_ERR=0.
- Zero register: WR_EN, WR_ADDR=0, WR_DATA=0x12345678; then ISSUE x0 -> read x0 = 0, RD_BUSY=0, ISSUE_STALL=0.
- Same-cycle read/write of x7 with data 0xA5A5A5A5:
  - With REGFILE_BYPASS_EN -> RD_DATA=0xA5A5A5A5 in the same cycle.
  - Without it -> old value, then 0xA5A5A5A5 the next cycle.
- Scoreboard saturation (PCW=2): issue x3 three times -> RD_BUSY=1 and a 4th issue gives ISSUE_STALL=1. Then three writebacks -> RD_BUSY=0 after the 3rd.
- Simultaneous issue+writeback on x9 with count 1 -> count stays 1, RD_BUSY=1. A further writeback -> RD_BUSY=0.
- Spurious writeback to x4 with count 0 -> data written, WB_ERR=1 and held until RESET. NRP=4: all four ports read distinct registers correctly in the same cycle.
